// File: rtl/eq_sweep_pkg.sv
// rtl/eq_sweep_pkg.sv - shared types and sizes for the exhaustive equivalence sweep controller
package eq_sweep_pkg;

    localparam int VEC_W   = 5;
    localparam int NUM_VEC = 32;
    localparam int CNT_W   = 6;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - settle-delay counter, expired once SETTLE_CYCLES cycles have been counted
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to zero (has priority over enable)
//   enable     : count one settle cycle
//   expired    : count has reached SETTLE_CYCLES-1 (this is the last settle cycle)
module sweep_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Four bits cover the legal range 1..15; the count can reach SETTLE_CYCLES
    // for one cycle before the controller leaves SETTLE and clears it.
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (clear) begin
            cnt <= 4'd0;
        end else if (enable) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign expired = (cnt == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/eq_sweep_ctrl.sv
// rtl/eq_sweep_ctrl.sv - walks all 32 five-bit vectors, samples a mismatch flag per vector, reports the result
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle request to begin a sweep (accepted in IDLE or DONE only)
//   mismatch_in    : compare flag from the checker under test, sampled only in SAMPLE
//   vec_out        : registered stimulus vector {a,b,c,d,e}
//   busy           : sweep in progress
//   done           : sweep finished, held until the next accepted start
//   pass           : no mismatches seen (only meaningful with done)
//   err_count      : number of vectors sampled with mismatch_in high
//   first_fail     : lowest failing vector, valid with first_fail_vld
//
// Build option: define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first failing vector.
module eq_sweep_ctrl
    import eq_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mismatch_in,
    output logic [VEC_W-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail,
    output logic             first_fail_vld
);

    state_t state, state_nxt;
    logic   settle_expired;
    logic   accept;

    assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && start;

    // The timer runs only while settling and is held cleared otherwise, so
    // every vector starts its settle period from zero.
    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != ST_SETTLE),
        .enable (state == ST_SETTLE),
        .expired(settle_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_expired) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
`ifdef SWEEP_STOP_ON_FAIL_EN
                if (mismatch_in || (vec_out == LAST_VEC)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SETTLE;
                end
`else
                if (vec_out == LAST_VEC) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SETTLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_count == '0);
    end

    // Result datapath. err_count tops out at NUM_VEC because each vector is
    // sampled exactly once, so it needs no saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out        <= '0;
            err_count      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (accept) begin
            vec_out        <= '0;
            err_count      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (state == ST_SAMPLE) begin
            if (mismatch_in) begin
                err_count <= err_count + CNT_W'(1);
                if (!first_fail_vld) begin
                    first_fail     <= vec_out;
                    first_fail_vld <= 1'b1;
                end
            end
            // The vector only advances when another settle period follows,
            // so it holds the last (or failing) vector into DONE.
            if (state_nxt == ST_SETTLE) begin
                vec_out <= vec_out + VEC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eq_sweep_ctrl.sv
// tb/tb_eq_sweep_ctrl.sv - randomized self-checking bench for eq_sweep_ctrl against a sweep-level model
module tb_eq_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [31:0] mask0, mask1;

    logic [4:0] vec0, vec1, ff0, ff1;
    logic [5:0] err0, err1;
    logic       busy0, busy1, done0, done1, pass0, pass1, ffv0, ffv1;
    logic       mis0, mis1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Mock checker: a vector fails when its bit is set in the mask.
    assign mis0 = mask0[vec0];
    assign mis1 = mask1[vec1];

    eq_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mismatch_in(mis0),
        .vec_out(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail(ff0), .first_fail_vld(ffv0)
    );

    eq_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mismatch_in(mis1),
        .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .first_fail_vld(ffv1)
    );

    // Sweep-level reference model.
    function automatic int m_first(input logic [31:0] m);
        for (int i = 0; i < 32; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int m_err(input logic [31:0] m);
        int n = 0;
`ifdef SWEEP_STOP_ON_FAIL_EN
        n = (m != 0) ? 1 : 0;
`else
        for (int i = 0; i < 32; i++) n += int'(m[i]);
`endif
        return n;
    endfunction

    function automatic int m_last_vec(input logic [31:0] m);
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (m != 0) return m_first(m);
`endif
        return 31;
    endfunction

    function automatic int m_len(input logic [31:0] m, input int sc);
        return (m_last_vec(m) + 1) * (sc + 1);
    endfunction

    // Pulses start, then follows the sweep cycle by cycle until done. Returns
    // the number of edges from the accept edge to done (-1 on timeout) and the
    // number of cycles whose vec_out/busy/done disagreed with the model.
    task automatic do_sweep(input int which, input int sc, input logic [31:0] m,
                            input int mid_start_vec, output int cycles, output int trace_bad);
        int len = m_len(m, sc);
        int k = 0;
        bit pulsed = 0;
        logic [4:0] v;
        logic b, d;
        int ev;
        cycles = -1;
        trace_bad = 0;
        @(negedge clk);
        if (which == 0) begin mask0 = m; start0 = 1'b1; end
        else begin mask1 = m; start1 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        while (k <= len + 10) begin
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            k++;
            if (which == 0) begin v = vec0; b = busy0; d = done0; end
            else begin v = vec1; b = busy1; d = done1; end
            ev = (k < len) ? k / (sc + 1) : m_last_vec(m);
            if (int'(v) != ev || b != (k < len) || d != (k >= len)) trace_bad++;
            if (d) begin cycles = k; break; end
            if (mid_start_vec >= 0 && !pulsed && int'(v) == mid_start_vec) begin
                pulsed = 1;
                if (which == 0) start0 = 1'b1; else start1 = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mask0 = '0; mask1 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({vec0, busy0, done0, pass0, err0, ff0, ffv0} !== 20'd0) begin errors++;
            $display("FAIL reset_outputs: got %h expected 0", {vec0, busy0, done0, pass0, err0, ff0, ffv0}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected busy=0 done=0", busy0, done0); end
    endtask

    task automatic check_result(input string name, input int which, input logic [31:0] m,
                                input int sc, input int cycles, input int trace_bad);
        logic [4:0] v, f; logic [5:0] e; logic p, fv;
        int ef = m_first(m);
        if (which == 0) begin v = vec0; f = ff0; e = err0; p = pass0; fv = ffv0; end
        else begin v = vec1; f = ff1; e = err1; p = pass1; fv = ffv1; end
        checks++; if (cycles != m_len(m, sc)) begin errors++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, cycles, m_len(m, sc)); end
        checks++; if (trace_bad != 0) begin errors++;
            $display("FAIL %s_trace: got %0d bad cycles expected 0", name, trace_bad); end
        checks++; if (e !== 6'(m_err(m))) begin errors++;
            $display("FAIL %s_err_count: got %0d expected %0d", name, e, m_err(m)); end
        checks++; if (p !== (m == 0)) begin errors++;
            $display("FAIL %s_pass: got %b expected %b", name, p, (m == 0)); end
        checks++; if (fv !== (m != 0) || (m != 0 && f !== 5'(ef))) begin errors++;
            $display("FAIL %s_first_fail: got vld=%b vec=%0d expected vld=%b vec=%0d", name, fv, f, (m != 0), ef); end
        checks++; if (v !== 5'(m_last_vec(m))) begin errors++;
            $display("FAIL %s_final_vec: got %0d expected %0d", name, v, m_last_vec(m)); end
    endtask

    task automatic test_clean_sweep();
        int c, t;
        do_sweep(0, 2, 32'h0, -1, c, t);
        check_result("clean", 0, 32'h0, 2, c, t);
    endtask

    task automatic test_two_fails();
        int c, t;
        logic [31:0] m = (32'h1 << 5) | (32'h1 << 20);
        do_sweep(0, 2, m, -1, c, t);
        check_result("two_fails", 0, m, 2, c, t);
    endtask

    task automatic test_single_fail();
        int c, t;
        logic [31:0] m = 32'h1 << 7;
        do_sweep(0, 2, m, -1, c, t);
        check_result("fail_at_7", 0, m, 2, c, t);
    endtask

    task automatic test_random();
        int c, t;
        logic [31:0] m;
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: m = $urandom & $urandom & $urandom;
                1: m = 32'h1 << $urandom_range(31, 0);
                default: m = $urandom;
            endcase
            do_sweep(0, 2, m, -1, c, t);
            check_result("random", 0, m, 2, c, t);
        end
    endtask

    task automatic test_start_ignored();
        int c, t;
        do_sweep(0, 2, 32'h0, 10, c, t);
        check_result("mid_start", 0, 32'h0, 2, c, t);
    endtask

    task automatic test_reset_mid_sweep();
        int c, t;
        bit hit = 0;
        @(negedge clk); mask0 = 32'h1 << 3; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (vec0 == 5'd12) begin hit = 1; break; end
        end
        checks++; if (!hit || err0 !== 6'd1) begin errors++;
            $display("FAIL reach_vec12: got reached=%0d err=%0d expected reached=1 err=1", hit, err0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({vec0, busy0, done0, pass0, err0, ff0, ffv0} !== 20'd0) begin errors++;
            $display("FAIL async_reset_mid: got %h expected 0", {vec0, busy0, done0, pass0, err0, ff0, ffv0}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0 || vec0 !== 5'd0) begin errors++;
            $display("FAIL no_restart_without_start: got busy=%b vec=%0d expected busy=0 vec=0", busy0, vec0); end
        do_sweep(0, 2, 32'h1 << 3, -1, c, t);
        check_result("after_reset", 0, 32'h1 << 3, 2, c, t);
    endtask

    task automatic test_back_to_back();
        int c, t;
        do_sweep(0, 2, 32'h8000_0001, -1, c, t);
        check_result("b2b_first", 0, 32'h8000_0001, 2, c, t);
        do_sweep(0, 2, 32'h0, -1, c, t);
        check_result("b2b_second", 0, 32'h0, 2, c, t);
    endtask

    task automatic test_all_fail_fast();
        int c, t;
        do_sweep(1, 1, 32'hFFFF_FFFF, -1, c, t);
        check_result("all_fail_sc1", 1, 32'hFFFF_FFFF, 1, c, t);
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_two_fails();
        test_single_fail();
        test_random();
        test_start_ignored();
        test_reset_mid_sweep();
        test_back_to_back();
        test_all_fail_fast();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
